// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller: state encoding,
// default drain length and drain-counter sizing.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        JUMP_WAIT = 2'd1,
        DRAIN     = 2'd2,
        HALTED    = 2'd3
    } state_t;

    localparam int DRAIN_CYCLES_DEF = 4;

    function automatic int drain_cnt_w(input int drain_cycles);
        return $clog2(drain_cycles + 1);
    endfunction

    localparam int DRAIN_CNT_W_DEF = drain_cnt_w(DRAIN_CYCLES_DEF);

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on en, sticks at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && !(&count)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Turns hazard-detector requests into PC / IF/ID write enables and ID/EX
// bubble selects; drains the pipeline on HALT and reports stall statistics.
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   RUN       | normal issue; stalls on load-use, accepts HALT
//   JUMP_WAIT | one cycle after a jump stop, o_jump_stop masks repeats
//   DRAIN     | inserting bubbles after HALT, counting down
//   HALTED    | pipeline frozen until i_restart
module pipeline_stall_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int STALL_CNT_W  = 32
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic                   i_enable,
    input  logic                   i_jmp_stop,
    input  logic                   i_not_load,
    input  logic                   i_halt,
    input  logic                   i_restart,
    output logic                   o_pc_write,
    output logic                   o_if_id_write,
    output logic                   o_id_ex_bubble,
    output logic                   o_jump_stop,
    output logic                   o_halted,
    output logic [STALL_CNT_W-1:0] o_stall_count
);

    localparam int CNT_W = drain_cnt_w(DRAIN_CYCLES);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] drain_cnt, drain_cnt_nxt;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= RUN;
            drain_cnt   <= '0;
            o_jump_stop <= 1'b0;
            o_halted    <= 1'b0;
        end else begin
            state       <= state_nxt;
            drain_cnt   <= drain_cnt_nxt;
            o_jump_stop <= (state_nxt == JUMP_WAIT);
            o_halted    <= (state_nxt == HALTED);
        end
    end

    always_comb begin
        state_nxt      = state;
        drain_cnt_nxt  = drain_cnt;
        o_pc_write     = 1'b0;
        o_if_id_write  = 1'b0;
        o_id_ex_bubble = 1'b0;
        if (i_enable) begin
            case (state)
                RUN: begin
                    if (i_not_load) begin
                        o_id_ex_bubble = 1'b1;
                        if (i_jmp_stop) state_nxt = JUMP_WAIT;
                    end else if (i_halt) begin
                        o_id_ex_bubble = 1'b1;
                        // The accept cycle is the first of the drain bubbles.
                        if (DRAIN_CYCLES <= 1) begin
                            state_nxt = HALTED;
                        end else begin
                            state_nxt     = DRAIN;
                            drain_cnt_nxt = CNT_W'(DRAIN_CYCLES - 1);
                        end
                    end else begin
                        o_pc_write    = 1'b1;
                        o_if_id_write = 1'b1;
                    end
                end
                JUMP_WAIT: begin
                    state_nxt = RUN;
                    if (i_not_load) begin
                        o_id_ex_bubble = 1'b1;
                    end else begin
                        o_pc_write    = 1'b1;
                        o_if_id_write = 1'b1;
                    end
                end
                DRAIN: begin
                    o_id_ex_bubble = 1'b1;
                    drain_cnt_nxt  = drain_cnt - CNT_W'(1);
                    if (drain_cnt <= CNT_W'(1)) begin
                        state_nxt     = HALTED;
                        drain_cnt_nxt = '0;
                    end
                end
                HALTED: begin
                    if (i_restart) state_nxt = RUN;
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    sat_counter #(
        .W(STALL_CNT_W)
    ) u_stall_cnt (
        .clk  (i_clk),
        .rst_n(i_reset_n),
        .en   (i_enable & o_id_ex_bubble),
        .count(o_stall_count)
    );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller: directed scenarios plus random traffic
// against a cycle-level behavioural model; a 2-bit-counter copy covers saturation.
module tb_pipeline_stall_controller;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable, jmp_stop, not_load, halt, restart;
    logic        pc_write, if_id_write, bubble, jump_stop, halted;
    logic [31:0] stall_count;
    logic        pc_write_s, if_id_write_s, bubble_s, jump_stop_s, halted_s;
    logic [1:0]  stall_count_s;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    bit     m_halted;
    bit     m_jump;
    int     m_drain_left;
    longint m_cnt;

    always #5 clk = ~clk;

    pipeline_stall_controller #(.DRAIN_CYCLES(D), .STALL_CNT_W(32)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_enable(enable), .i_jmp_stop(jmp_stop),
        .i_not_load(not_load), .i_halt(halt), .i_restart(restart),
        .o_pc_write(pc_write), .o_if_id_write(if_id_write), .o_id_ex_bubble(bubble),
        .o_jump_stop(jump_stop), .o_halted(halted), .o_stall_count(stall_count)
    );

    pipeline_stall_controller #(.DRAIN_CYCLES(D), .STALL_CNT_W(2)) dut_sat (
        .i_clk(clk), .i_reset_n(rst_n), .i_enable(enable), .i_jmp_stop(jmp_stop),
        .i_not_load(not_load), .i_halt(halt), .i_restart(restart),
        .o_pc_write(pc_write_s), .o_if_id_write(if_id_write_s), .o_id_ex_bubble(bubble_s),
        .o_jump_stop(jump_stop_s), .o_halted(halted_s), .o_stall_count(stall_count_s)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_halted     = 1'b0;
        m_jump       = 1'b0;
        m_drain_left = 0;
        m_cnt        = 0;
    endtask

    // One clock: drive at negedge, compare just after, then advance the model.
    task automatic step(input bit en, input bit nl, input bit jmp, input bit hlt, input bit rs);
        bit     e_pc, e_bub, n_halted, n_jump;
        int     n_drain;
        longint e_sat;
        @(negedge clk);
        enable = en; not_load = nl; jmp_stop = jmp; halt = hlt; restart = rs;
        #1;
        e_pc = 1'b0; e_bub = 1'b0;
        n_halted = m_halted; n_jump = m_jump; n_drain = m_drain_left;
        if (en) begin
            if (m_halted) begin
                if (rs) n_halted = 1'b0;
            end else if (m_drain_left > 0) begin
                e_bub   = 1'b1;
                n_drain = m_drain_left - 1;
                if (n_drain == 0) n_halted = 1'b1;
            end else if (m_jump) begin
                e_bub  = nl;
                e_pc   = !nl;
                n_jump = 1'b0;
            end else if (nl) begin
                e_bub  = 1'b1;
                n_jump = jmp;
            end else if (hlt) begin
                e_bub   = 1'b1;
                n_drain = D - 1;
                if (n_drain == 0) n_halted = 1'b1;
            end else begin
                e_pc = 1'b1;
            end
        end
        e_sat = (m_cnt > 3) ? 3 : m_cnt;
        check_val("pc_write",    64'(pc_write),      64'(e_pc));
        check_val("if_id_write", 64'(if_id_write),   64'(e_pc));
        check_val("bubble",      64'(bubble),        64'(e_bub));
        check_val("jump_stop",   64'(jump_stop),     64'(m_jump));
        check_val("halted",      64'(halted),        64'(m_halted));
        check_val("stall_count", 64'(stall_count),   64'(m_cnt));
        check_val("sat_count",   64'(stall_count_s), 64'(e_sat));
        check_val("sat_bubble",  64'(bubble_s),      64'(e_bub));
        m_halted     = n_halted;
        m_jump       = n_jump;
        m_drain_left = n_drain;
        if (en && e_bub) m_cnt++;
    endtask

    task automatic check_reset_vals();
        check_val("rst_pc_write",  64'(pc_write),      64'd1);
        check_val("rst_if_id",     64'(if_id_write),   64'd1);
        check_val("rst_bubble",    64'(bubble),        64'd0);
        check_val("rst_jump_stop", 64'(jump_stop),     64'd0);
        check_val("rst_halted",    64'(halted),        64'd0);
        check_val("rst_count",     64'(stall_count),   64'd0);
        check_val("rst_sat_count", 64'(stall_count_s), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        enable = 1'b1; jmp_stop = 1'b0; not_load = 1'b0; halt = 1'b0; restart = 1'b0;
        model_reset();
        #3;
        check_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;

        // idle, single load stall, jump stop then held jmp
        step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        check_val("count_after_stalls", 64'(stall_count), 64'd2);

        // halt, drain, sit halted, restart
        step(1, 0, 0, 1, 0);
        for (int i = 0; i < D + 2; i++) step(1, 0, 0, 1, 0);
        check_val("halted_after_drain", 64'(halted), 64'd1);
        check_val("count_after_drain",  64'(stall_count), 64'd6);
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);

        // stall beats halt, then halt alone enters drain
        step(1, 1, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);

        // freeze mid-drain, then asynchronous reset between edges
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        @(negedge clk);
        enable = 1'b1; not_load = 1'b0; jmp_stop = 1'b0; halt = 1'b0; restart = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // continuous stalls push the narrow counter into saturation
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0);
        check_val("sat_hold", 64'(stall_count_s), 64'd3);
        step(1, 0, 0, 0, 0);

        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 25,
                 $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 20,
                 $urandom_range(0, 99) < 20);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
